// File: rtl/rob_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rob_commit_pkg
// Brief   : Shared constants, entry payload type and helpers for the reorder
//           buffer / commit stage.
// Revision: 1.0 - initial release
// ============================================================================
package rob_commit_pkg;

    localparam int ROB_SIZE     = 16;
    localparam int ROB_LR_WIDTH = 4;
    localparam int DATA_WIDTH   = 32;
    localparam int MAX_REG      = 32;
    localparam int REG_W        = 5;
    localparam int PC_W         = 32;

    // Fields captured at dispatch time; result fields live in separate arrays.
    typedef struct packed {
        logic             has_rd;
        logic [REG_W-1:0] rd;
        logic             is_br;
        logic [PC_W-1:0]  alt_pc;
    } rob_payload_t;

    // Register index as seen by the register file commit port.
    function automatic logic [DATA_WIDTH-1:0] zext_rd(input logic [REG_W-1:0] rd);
        return {{(DATA_WIDTH-REG_W){1'b0}}, rd};
    endfunction

endpackage : rob_commit_pkg
`default_nettype wire

// File: rtl/rob_commit_lookup.sv
`default_nettype none
// ============================================================================
// Module  : rob_lookup
// Brief   : Combinational tag-indexed operand read from the reorder buffer,
//           with same-cycle bypass from the writeback bus.
// Revision: 1.0 - initial release
// ============================================================================
module rob_lookup #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic [ROB_SIZE-1:0] ready_vec,
    input  logic [31:0]         value_arr [ROB_SIZE],
    input  logic [TAG_W-1:0]    tag,
    input  logic                wb_valid,
    input  logic [TAG_W-1:0]    wb_tag,
    input  logic [31:0]         wb_value,
    output logic                ready,
    output logic [31:0]         value
);

    logic w_hit;

    // A result on the bus this cycle wins over the stored copy.
    always_comb begin
        w_hit = wb_valid && (wb_tag == tag);
        ready = w_hit || ready_vec[tag];
        value = w_hit ? wb_value : value_arr[tag];
    end

endmodule : rob_lookup
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
// Module  : rob_commit
// Brief   : Reorder buffer with in-order commit into the architectural
//           register file and flush generation on a mispredicted branch.
//           Optional macro ROB_QUERY_EN enables the operand lookup ports;
//           without it q*_ready / q*_value are tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module rob_commit #(
    parameter int ROB_SIZE = rob_commit_pkg::ROB_SIZE,
    parameter int TAG_W    = rob_commit_pkg::ROB_LR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic             alloc_has_rd,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_br,
    input  logic [31:0]      alloc_alt_pc,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_value,
    input  logic             wb_mispred,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_value,
    output logic [31:0]      q2_value,
    output logic [31:0]      commit_rd,
    output logic             ROB_to_Reg_needchange,
    output logic [31:0]      reg_reg_commit_rd_,
    input  logic [TAG_W-1:0] reg_reorder_commit_rd,
    output logic             ROB_to_Reg_needchange2,
    output logic             reg_busy_commit_rd_,
    output logic             Clear_flag,
    output logic [31:0]      redirect_pc
);

    import rob_commit_pkg::*;

    localparam logic [TAG_W:0] C_FULL = (TAG_W+1)'(ROB_SIZE);

    rob_payload_t        r_payload [ROB_SIZE];
    logic [31:0]         r_value   [ROB_SIZE];
    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_mispred;
    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;

    logic w_active;
    logic w_do_alloc;
    logic w_do_wb;
    logic w_do_commit;

    // Registered count only: a slot freed this cycle is not reusable until next.
    assign alloc_ready = (r_count < C_FULL);
    assign alloc_tag   = r_tail;

    // Everything is frozen while rdy is low and suppressed during a flush cycle.
    always_comb begin
        w_active    = rdy && !Clear_flag;
        w_do_alloc  = w_active && alloc_valid && alloc_ready;
        w_do_wb     = w_active && wb_valid && r_busy[wb_tag];
        w_do_commit = w_active && r_busy[r_head] && r_ready[r_head];
    end

    // Commit port toward the register file, zero whenever no commit happens.
    always_comb begin
        ROB_to_Reg_needchange  = w_do_commit;
        ROB_to_Reg_needchange2 = w_do_commit && (reg_reorder_commit_rd == r_head);
        commit_rd              = (w_do_commit && r_payload[r_head].has_rd)
                                 ? zext_rd(r_payload[r_head].rd) : '0;
        reg_reg_commit_rd_     = w_do_commit ? r_value[r_head] : '0;
        reg_busy_commit_rd_    = 1'b0;
    end

    // Entry state, pointers, occupancy and the registered flush request.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_payload[i] <= '0;
                r_value[i]   <= '0;
            end
            r_busy      <= '0;
            r_ready     <= '0;
            r_mispred   <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            Clear_flag  <= 1'b0;
            redirect_pc <= '0;
        end else if (rdy) begin
            if (Clear_flag) begin
                r_busy      <= '0;
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
                Clear_flag  <= 1'b0;
                redirect_pc <= '0;
            end else begin
                if (w_do_alloc) begin
                    r_payload[r_tail] <= '{has_rd: alloc_has_rd, rd: alloc_rd,
                                           is_br: alloc_is_br, alt_pc: alloc_alt_pc};
                    r_busy[r_tail]    <= 1'b1;
                    r_ready[r_tail]   <= 1'b0;
                    r_tail            <= r_tail + 1'b1;
                end
                if (w_do_wb) begin
                    r_ready[wb_tag]   <= 1'b1;
                    r_value[wb_tag]   <= wb_value;
                    r_mispred[wb_tag] <= wb_mispred;
                end
                if (w_do_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                    // The branch itself retires; younger entries are flushed next cycle.
                    if (r_payload[r_head].is_br && r_mispred[r_head]) begin
                        Clear_flag  <= 1'b1;
                        redirect_pc <= r_payload[r_head].alt_pc;
                    end
                end
                r_count <= r_count + {{TAG_W{1'b0}}, w_do_alloc}
                                   - {{TAG_W{1'b0}}, w_do_commit};
            end
        end
    end

`ifdef ROB_QUERY_EN
    rob_lookup #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_lookup_q1 (
        .ready_vec (r_ready),
        .value_arr (r_value),
        .tag       (q1_tag),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_value  (wb_value),
        .ready     (q1_ready),
        .value     (q1_value)
    );

    rob_lookup #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_lookup_q2 (
        .ready_vec (r_ready),
        .value_arr (r_value),
        .tag       (q2_tag),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_value  (wb_value),
        .ready     (q2_ready),
        .value     (q2_value)
    );
`else
    // Lookup ports stay on the boundary but carry no logic in this build.
    logic unused_q_tags;
    assign unused_q_tags = ^{q1_tag, q2_tag};
    assign q1_ready = 1'b0;
    assign q2_ready = 1'b0;
    assign q1_value = '0;
    assign q2_value = '0;
`endif

endmodule : rob_commit
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_commit
// Brief   : Self-checking bench for rob_commit: directed scenarios with literal
//           expectations plus a randomized run against a queue-based model of
//           the in-flight instruction window.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rob_commit;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        alloc_valid, alloc_has_rd, alloc_is_br;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_alt_pc;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        wb_valid, wb_mispred;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value;
    logic [3:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic [31:0] commit_rd;
    logic        ROB_to_Reg_needchange;
    logic [31:0] reg_reg_commit_rd_;
    logic [3:0]  reg_reorder_commit_rd;
    logic        ROB_to_Reg_needchange2;
    logic        reg_busy_commit_rd_;
    logic        Clear_flag;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .alloc_valid            (alloc_valid),
        .alloc_has_rd           (alloc_has_rd),
        .alloc_rd               (alloc_rd),
        .alloc_is_br            (alloc_is_br),
        .alloc_alt_pc           (alloc_alt_pc),
        .alloc_ready            (alloc_ready),
        .alloc_tag              (alloc_tag),
        .wb_valid               (wb_valid),
        .wb_tag                 (wb_tag),
        .wb_value               (wb_value),
        .wb_mispred             (wb_mispred),
        .q1_tag                 (q1_tag),
        .q2_tag                 (q2_tag),
        .q1_ready               (q1_ready),
        .q2_ready               (q2_ready),
        .q1_value               (q1_value),
        .q2_value               (q2_value),
        .commit_rd              (commit_rd),
        .ROB_to_Reg_needchange  (ROB_to_Reg_needchange),
        .reg_reg_commit_rd_     (reg_reg_commit_rd_),
        .reg_reorder_commit_rd  (reg_reorder_commit_rd),
        .ROB_to_Reg_needchange2 (ROB_to_Reg_needchange2),
        .reg_busy_commit_rd_    (reg_busy_commit_rd_),
        .Clear_flag             (Clear_flag),
        .redirect_pc            (redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: in-order window of live instructions
    typedef struct {
        int          tag;
        bit          has_rd;
        int          rd;
        bit          is_br;
        logic [31:0] alt_pc;
        bit          done;
        logic [31:0] val;
        bit          mis;
    } ent_t;

    ent_t        ent[$];
    int          m_head;
    bit          m_clear;
    logic [31:0] m_redirect;
    bit          m_ready [16];
    logic [31:0] m_value [16];

    task automatic model_reset();
        ent.delete();
        m_head     = 0;
        m_clear    = 0;
        m_redirect = '0;
        for (int i = 0; i < 16; i++) begin
            m_ready[i] = 0;
            m_value[i] = '0;
        end
    endtask

    task automatic model_cycle();
        int          cnt = ent.size();
        int          tail = (m_head + cnt) % 16;
        bit          commit = rdy && !m_clear && (cnt > 0) && ent[0].done;
        bit          flush_req = 0;
        logic [31:0] alt = '0;
        logic        q1r, q2r;
        logic [31:0] q1v, q2v;
        ent_t        e;

`ifdef ROB_QUERY_EN
        q1r = m_ready[q1_tag] || (wb_valid && wb_tag == q1_tag);
        q1v = (wb_valid && wb_tag == q1_tag) ? wb_value : m_value[q1_tag];
        q2r = m_ready[q2_tag] || (wb_valid && wb_tag == q2_tag);
        q2v = (wb_valid && wb_tag == q2_tag) ? wb_value : m_value[q2_tag];
`else
        q1r = 0; q1v = '0; q2r = 0; q2v = '0;
`endif

        chk("m_alloc_ready", alloc_ready, (cnt < 16));
        chk("m_alloc_tag", alloc_tag, tail);
        chk("m_needchange", ROB_to_Reg_needchange, commit);
        chk("m_needchange2", ROB_to_Reg_needchange2, commit && (reg_reorder_commit_rd == 4'(m_head)));
        chk("m_commit_rd", commit_rd, (commit && ent[0].has_rd) ? ent[0].rd : 0);
        chk("m_commit_val", reg_reg_commit_rd_, commit ? ent[0].val : 32'h0);
        chk("m_busy_rel", reg_busy_commit_rd_, 0);
        chk("m_clear", Clear_flag, m_clear);
        if (m_clear) chk("m_redirect", redirect_pc, m_redirect);
        chk("m_q1_ready", q1_ready, q1r);
        chk("m_q1_value", q1_value, q1v);
        chk("m_q2_ready", q2_ready, q2r);
        chk("m_q2_value", q2_value, q2v);

        if (!rdy) return;
        if (m_clear) begin
            ent.delete();
            m_head  = 0;
            m_clear = 0;
            return;
        end
        if (commit) begin
            flush_req = ent[0].is_br && ent[0].mis;
            alt       = ent[0].alt_pc;
        end
        if (wb_valid) begin
            foreach (ent[i]) begin
                if (ent[i].tag == int'(wb_tag)) begin
                    ent[i].done = 1;
                    ent[i].val  = wb_value;
                    ent[i].mis  = wb_mispred;
                    m_ready[wb_tag] = 1;
                    m_value[wb_tag] = wb_value;
                end
            end
        end
        if (alloc_valid && cnt < 16) begin
            e = '{tag: tail, has_rd: alloc_has_rd, rd: int'(alloc_rd), is_br: alloc_is_br,
                  alt_pc: alloc_alt_pc, done: 0, val: '0, mis: 0};
            ent.push_back(e);
            m_ready[tail] = 0;
        end
        if (commit) begin
            void'(ent.pop_front());
            m_head = (m_head + 1) % 16;
            if (flush_req) begin
                m_clear    = 1;
                m_redirect = alt;
            end
        end
    endtask

    // Single compare point per cycle, on the inactive edge.
    always @(negedge clk) begin
        if (rst) model_reset();
        else     model_cycle();
    end

    // ---------------- stimulus helpers
    task automatic idle();
        alloc_valid = 0; alloc_has_rd = 0; alloc_rd = '0; alloc_is_br = 0; alloc_alt_pc = '0;
        wb_valid = 0; wb_tag = '0; wb_value = '0; wb_mispred = 0;
        q1_tag = '0; q2_tag = '0; reg_reorder_commit_rd = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rdy = 1;
        rst = 1;
        next();
        next();
        rst = 0;
    endtask

    task automatic alloc_one(input logic [4:0] rd, input logic br, input logic [31:0] pc);
        next();
        idle();
        alloc_valid = 1; alloc_has_rd = 1; alloc_rd = rd; alloc_is_br = br; alloc_alt_pc = pc;
    endtask

    initial begin
        int alloc_p;
        idle();
        rst = 1;
        rdy = 1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_clear", Clear_flag, 0);
        chk("rst_needchange", ROB_to_Reg_needchange, 0);
        chk("rst_commit_rd", commit_rd, 0);
        chk("rst_q1_ready", q1_ready, 0);

        // Fill all 16 entries; tags issue 0..15
        for (int i = 0; i < 16; i++) begin
            alloc_one(5'(i), 0, 32'h0);
            @(negedge clk);
            chk("fill_tag", alloc_tag, i);
            chk("fill_ready", alloc_ready, 1);
        end
        next();
        idle();
        @(negedge clk);
        chk("full_not_ready", alloc_ready, 0);

        // Full: writeback tag 0, allocation refused in the commit cycle
        next();
        wb_valid = 1; wb_tag = 4'd0; wb_value = 32'h11;
        next();
        idle();
        alloc_valid = 1; alloc_has_rd = 1; alloc_rd = 5'd7;
        @(negedge clk);
        chk("full_commit", ROB_to_Reg_needchange, 1);
        chk("full_commit_val", reg_reg_commit_rd_, 32'h11);
        chk("full_refuse", alloc_ready, 0);
        next();
        @(negedge clk);
        chk("wrap_ready", alloc_ready, 1);
        chk("wrap_tag", alloc_tag, 0);
        next();
        idle();

        // rd=5 twice; register file's tag points at the younger one
        do_reset();
        alloc_one(5'd5, 0, 32'h0);
        alloc_one(5'd5, 0, 32'h0);
        next();
        idle();
        wb_valid = 1; wb_tag = 4'd0; wb_value = 32'hAA; reg_reorder_commit_rd = 4'd1;
        next();
        wb_tag = 4'd1; wb_value = 32'hBB;
        @(negedge clk);
        chk("rd5_commit", ROB_to_Reg_needchange, 1);
        chk("rd5_rd", commit_rd, 5);
        chk("rd5_val", reg_reg_commit_rd_, 32'hAA);
        chk("rd5_nc2_old", ROB_to_Reg_needchange2, 0);
        next();
        wb_valid = 0;
        @(negedge clk);
        chk("rd5_val2", reg_reg_commit_rd_, 32'hBB);
        chk("rd5_nc2_new", ROB_to_Reg_needchange2, 1);

        // Mispredicted branch followed by three younger entries
        do_reset();
        alloc_one(5'd3, 1, 32'h1000);
        alloc_one(5'd4, 0, 32'h0);
        alloc_one(5'd6, 0, 32'h0);
        alloc_one(5'd8, 0, 32'h0);
        next();
        idle();
        wb_valid = 1; wb_tag = 4'd0; wb_value = 32'h77; wb_mispred = 1;
        next();
        idle();
        @(negedge clk);
        chk("br_commit", ROB_to_Reg_needchange, 1);
        chk("br_commit_rd", commit_rd, 3);
        chk("br_no_clear_yet", Clear_flag, 0);
        next();
        alloc_valid = 1; alloc_has_rd = 1; alloc_rd = 5'd9;
        wb_valid = 1; wb_tag = 4'd1; wb_value = 32'h5;
        @(negedge clk);
        chk("br_clear", Clear_flag, 1);
        chk("br_redirect", redirect_pc, 32'h1000);
        chk("br_flush_no_commit", ROB_to_Reg_needchange, 0);
        next();
        idle();
        @(negedge clk);
        chk("br_clear_low", Clear_flag, 0);
        chk("br_empty_tag", alloc_tag, 0);
        chk("br_empty_ready", alloc_ready, 1);

        // Lookup with same-cycle writeback bypass
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(5'(i + 1), 0, 32'h0);
        next();
        idle();
        wb_valid = 1; wb_tag = 4'd3; wb_value = 32'h55; q1_tag = 4'd3; q2_tag = 4'd2;
        @(negedge clk);
`ifdef ROB_QUERY_EN
        chk("q1_bypass_ready", q1_ready, 1);
        chk("q1_bypass_value", q1_value, 32'h55);
`else
        chk("q1_off_ready", q1_ready, 0);
        chk("q1_off_value", q1_value, 0);
`endif
        chk("q2_not_ready", q2_ready, 0);

        // rdy low for 5 cycles with allocation and writeback requested
        next();
        idle();
        rdy = 0;
        alloc_valid = 1; alloc_has_rd = 1; alloc_rd = 5'd12;
        wb_valid = 1; wb_tag = 4'd0; wb_value = 32'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("frz_tag", alloc_tag, 4);
            chk("frz_commit", ROB_to_Reg_needchange, 0);
            next();
        end
        rdy = 1;
        idle();
        @(negedge clk);
        chk("frz_after_tag", alloc_tag, 4);
        chk("frz_after_nocommit", ROB_to_Reg_needchange, 0);
        next();
        wb_valid = 1; wb_tag = 4'd0; wb_value = 32'h99;
        next();
        idle();
        @(negedge clk);
        chk("resume_commit", ROB_to_Reg_needchange, 1);
        chk("resume_val", reg_reg_commit_rd_, 32'h99);

        // Randomized run with varying allocation pressure
        alloc_p = 5;
        for (int c = 0; c < 4000; c++) begin
            next();
            if (c % 200 == 0) alloc_p = $urandom_range(1, 9);
            rdy          = ($urandom_range(0, 9) != 0);
            alloc_valid  = ($urandom_range(0, 9) < alloc_p);
            alloc_has_rd = ($urandom_range(0, 3) != 0);
            alloc_rd     = 5'($urandom);
            alloc_is_br  = ($urandom_range(0, 3) == 0);
            alloc_alt_pc = $urandom;
            wb_valid     = ($urandom_range(0, 9) < 6);
            if (ent.size() > 0 && $urandom_range(0, 3) != 0)
                wb_tag = 4'(ent[$urandom_range(0, ent.size() - 1)].tag);
            else
                wb_tag = 4'($urandom);
            wb_value     = $urandom;
            wb_mispred   = ($urandom_range(0, 19) == 0);
            q1_tag       = ($urandom_range(0, 1) != 0) ? wb_tag : 4'($urandom);
            q2_tag       = 4'($urandom);
            reg_reorder_commit_rd = ($urandom_range(0, 1) != 0) ? 4'(m_head) : 4'($urandom);
        end
        next();
        idle();
        rdy = 1;
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rob_commit
`default_nettype wire
